// File: rtl/multi_bcd_converter.sv
// Multi-channel binary-to-BCD converter: shared double-dabble controller, one
// shift-and-correct iteration per clock. Optional macro BCD_BLANK_EN blanks leading zero digits.
module multi_bcd_converter #(
  parameter int INPUT_WIDTH    = 16,
  parameter int DECIMAL_DIGITS = 5,
  parameter int CHANNELS       = 2
) (
  input  logic                               i_Clock,
  input  logic                               i_Reset,
  input  logic [CHANNELS*INPUT_WIDTH-1:0]    i_Binary,
  input  logic                               i_Start,
  output logic                               o_Busy,
  output logic [CHANNELS*DECIMAL_DIGITS*4-1:0] o_BCD,
  output logic [CHANNELS-1:0]                o_Overflow,
  output logic                               o_DV
);

  localparam int CNT_W = $clog2(INPUT_WIDTH + 1);
  localparam int BCD_W = DECIMAL_DIGITS * 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t                            state_q;
  logic [CNT_W-1:0]                  cnt_q;
  logic [CHANNELS*INPUT_WIDTH-1:0]   bin_q, bin_iter;
  logic [CHANNELS*BCD_W-1:0]         bcd_q, bcd_iter, bcd_out;
  logic [CHANNELS-1:0]               ovf_q, ovf_iter;
  logic [BCD_W-1:0]                  corr;
  logic [3:0]                        digit;

  // One double-dabble step for every channel: correct, then shift the binary MSB in.
  always_comb begin
    bin_iter = '0;
    bcd_iter = '0;
    ovf_iter = ovf_q;
    corr     = '0;
    digit    = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      for (int unsigned d = 0; d < DECIMAL_DIGITS; d++) begin
        digit = bcd_q[(k*DECIMAL_DIGITS + d)*4 +: 4];
        corr[d*4 +: 4] = (digit > 4'd4) ? digit + 4'd3 : digit;
      end
      ovf_iter[k] = ovf_q[k] | corr[BCD_W-1];
      bcd_iter[k*BCD_W +: BCD_W] = {corr[BCD_W-2:0], bin_q[k*INPUT_WIDTH + INPUT_WIDTH-1]};
      bin_iter[k*INPUT_WIDTH +: INPUT_WIDTH] = bin_q[k*INPUT_WIDTH +: INPUT_WIDTH] << 1;
    end
  end

`ifdef BCD_BLANK_EN
  logic lead;

  // Walk down from the top digit; blanking stops at the first non-zero digit.
  always_comb begin
    bcd_out = bcd_q;
    lead    = 1'b0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      lead = ~ovf_q[k];
      for (int unsigned d = DECIMAL_DIGITS-1; d >= 1; d--) begin
        if (lead && (bcd_q[(k*DECIMAL_DIGITS + d)*4 +: 4] == 4'd0))
          bcd_out[(k*DECIMAL_DIGITS + d)*4 +: 4] = 4'hF;
        else
          lead = 1'b0;
      end
    end
  end
`else
  always_comb begin
    bcd_out = bcd_q;
  end
`endif

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      ovf_q      <= '0;
      o_BCD      <= '0;
      o_Overflow <= '0;
      o_DV       <= 1'b0;
      o_Busy     <= 1'b0;
    end else begin
      o_DV <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_Start) begin
            bin_q   <= i_Binary;
            bcd_q   <= '0;
            ovf_q   <= '0;
            cnt_q   <= '0;
            o_Busy  <= 1'b1;
            state_q <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          bin_q <= bin_iter;
          bcd_q <= bcd_iter;
          ovf_q <= ovf_iter;
          if (cnt_q == CNT_W'(INPUT_WIDTH - 1))
            state_q <= S_DONE;
          else
            cnt_q <= cnt_q + CNT_W'(1);
        end
        S_DONE: begin
          o_BCD      <= bcd_out;
          o_Overflow <= ovf_q;
          o_DV       <= 1'b1;
          o_Busy     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: begin
          o_Busy  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/multi_bcd_converter.md
# multi_bcd_converter

Parametrised multi-channel binary-to-BCD converter for the score/timer display path. It converts CHANNELS unsigned binary values in parallel with a shared double-dabble controller, at one shift-and-correct iteration per clock. It adds a busy/start handshake, per-channel overflow flags and optional leading-zero blanking. It sits between the game-state counters and the seven-segment or HUD digit drivers.

## Interface
- INPUT_WIDTH, 16: bit width of each channel's binary input; must be at least 1.
- DECIMAL_DIGITS, 5: BCD digits per channel; must be at least 1.
- CHANNELS, 2: number of independent values converted together; must be at least 1.

- i_Clock  in  1  sole clock; all logic on the rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Binary  in  CHANNELS*INPUT_WIDTH  packed inputs; channel k at [k*INPUT_WIDTH +: INPUT_WIDTH].
- i_Start  in  1  conversion request; sampled only while o_Busy=0.
- o_Busy  out  1  high while a conversion is in progress.
- o_BCD  out  CHANNELS*DECIMAL_DIGITS*4  packed results; channel k at [k*DECIMAL_DIGITS*4 +: DECIMAL_DIGITS*4]; digit 0 is least significant.
- o_Overflow  out  CHANNELS  per channel; set when the value exceeds 10^DECIMAL_DIGITS-1.
- o_DV  out  1  one-cycle pulse marking new o_BCD/o_Overflow.

## Operation
- State machine:
  - S_IDLE -> S_CONVERT when i_Start=1. At that edge, capture i_Binary into the shift registers, clear the working BCD and overflow registers, and clear the iteration counter.
  - S_CONVERT: one iteration per cycle for INPUT_WIDTH cycles -> S_DONE after the iteration with counter = INPUT_WIDTH-1.
  - S_DONE: copy the working BCD and overflow into the output registers, pulse o_DV, go to S_IDLE.
  - Unreachable encodings -> S_IDLE.
- Iteration, per channel, all digits in the same cycle:
  1. Every working digit greater than 4 gets +3 (4-bit result).
  2. The whole BCD vector shifts left by 1; the binary register MSB enters digit 0 bit 0.
  3. The binary register shifts left by 1.
  4. The bit shifted out of the top digit (bit 3 after correction) ORs into that channel's sticky overflow.
- When a channel overflows, o_BCD still holds the value mod 10^DECIMAL_DIGITS.
- The iteration counter is $clog2(INPUT_WIDTH+1) bits wide.
- o_Busy = (state != S_IDLE).
- o_BCD and o_Overflow are registered and hold their last result until the next S_DONE.
- i_Start while busy is ignored and not queued. Input changes after capture have no effect.

## Timing
- Reset values: o_BCD=0, o_Overflow=0, o_DV=0, o_Busy=0, state S_IDLE, counter 0.
- Reset has priority over every other condition, including mid-conversion. The conversion in flight is discarded and o_DV is not asserted.
- Cycle timing, with the start accepted at edge E0:
  - o_Busy is high after E0.
  - S_CONVERT covers edges E1..E_INPUT_WIDTH.
  - At edge E_(INPUT_WIDTH+1), o_BCD is updated and o_DV goes high for exactly one cycle. o_Busy goes low at the same edge.
- Latency from start edge to o_DV: INPUT_WIDTH+1 cycles.
- Back-to-back: i_Start held high during the o_DV cycle is accepted at the next edge. The throughput period is INPUT_WIDTH+2 cycles.
- When INPUT_WIDTH=1, S_CONVERT lasts one cycle.

## Configuration
- BCD_BLANK_EN defined: in the S_DONE copy, each contiguous leading zero digit of a channel, counted from the most significant digit down, is replaced by 4'hF (blank code). Digit 0 is never blanked. Overflowed channels are not blanked.
- BCD_BLANK_EN undefined: raw BCD with leading zeros. No blanking logic is present.

## Test plan
- Defaults, ch0=12345, ch1=0, single i_Start -> o_DV exactly 17 cycles after the start edge. o_BCD ch0=0x12345, ch1=0x00000. o_Overflow=2'b00. o_Busy high for 17 cycles.
- DECIMAL_DIGITS=4, ch0=65535, ch1=9999 -> ch0=0x5535 with overflow bit 1. ch1=0x9999 with overflow bit 0.
- Busy handling: i_Start pulsed again 5 cycles into a conversion with different inputs -> ignored. One o_DV, carrying the first inputs.
- Back-to-back: i_Start held high continuously -> o_DV every 18 cycles, each carrying the i_Binary value present at its own accept edge.
- Reset: i_Reset asserted 8 cycles into a conversion -> next cycle all outputs are 0 and o_Busy=0, no o_DV. A following conversion of 42 gives 0x00042.
- BCD_BLANK_EN defined: ch0=42, ch1=0 -> ch0=0xFFF42, ch1=0xFFFF0. With the macro undefined: 0x00042 and 0x00000.
